// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the 3x3 Sobel matrix stage.
// Tracks col/row of the incoming pixel stream, drives the line-buffer shift
// and matrix advance enables, tags each loaded window as full or border,
// flushes the matrix pipeline at end of frame and qualifies full-window results.
module sobel_frame_ctrl #(
    parameter int PIC_WIDTH  = 250,
    parameter int PIC_HEIGHT = 250,
    parameter int WIDTH      = 8,
    parameter int MAT_LAT    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [WIDTH-1:0] mat_dout,
    output logic             lb_shift,
    output logic             mat_valid_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(PIC_WIDTH);
    localparam int RW = $clog2(PIC_HEIGHT);
    localparam int FW = (MAT_LAT > 1) ? $clog2(MAT_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [FW-1:0]        flush_q, flush_d;
    logic [MAT_LAT-1:0]   tag_q, tag_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 full;

    // Next-state, counters, window tag pipe and enables
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        flush_d      = flush_q;
        tag_d        = tag_q;
        lb_shift     = 1'b0;
        mat_valid_in = 1'b0;
        full         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                lb_shift     = pix_valid;
                mat_valid_in = pix_valid;
                if (pix_valid) begin
                    full = (row_q >= RW'(2)) && (col_q >= CW'(2));
                    if (col_q == CW'(PIC_WIDTH - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(PIC_HEIGHT - 1)) begin
                            row_d   = '0;
                            flush_d = '0;
                            state_d = S_FLUSH;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_FLUSH: begin
                // Advance the matrix with no new pixels so the last windows drain
                mat_valid_in = 1'b1;
                if (flush_q == FW'(MAT_LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                col_d   = '0;
                row_d   = '0;
                flush_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (mat_valid_in) begin
            tag_d[0] = full;
            for (int unsigned i = 1; i < MAT_LAT; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end
    end

    // Registered status outputs
    always_comb begin
        out_valid_d  = mat_valid_in & tag_q[MAT_LAT-1];
        busy_d       = (state_d == S_RUN) || (state_d == S_FLUSH);
        frame_done_d = (state_q == S_DONE);
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            flush_q      <= '0;
            tag_q        <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            flush_q      <= flush_d;
            tag_q        <= tag_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = mat_dout;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
